// File: rtl/dff.sv
// Positive-edge D flip-flop with asynchronous active-high reset.
// This is the basic storage element of the CPU datapath: registers, the PC and the flag bits.
module dff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  input  logic             rst
);

  // Reset is in the sensitivity list, so it overrides any clock edge.
  // The nonblocking capture lets chained instances act as a race-free shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) Q <= RST_VAL;
    else     Q <= D;
  end

endmodule

// File: tb/tb_dff.sv
// Scoreboard bench for dff.
// It covers a 1-bit instance (RST_VAL=0) and a 4-bit instance (RST_VAL=4'hA) on a shared clk/rst.
module tb_dff;

  logic       clk;
  logic       rst;
  logic       d1;
  logic       q1;
  logic [3:0] d4;
  logic [3:0] q4;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string      tag;
    bit         wide;
    logic [3:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];

  dff u_narrow (
    .clk (clk),
    .D   (d1),
    .Q   (q1),
    .rst (rst)
  );

  dff #(.WIDTH(4), .RST_VAL(4'hA)) u_wide (
    .clk (clk),
    .D   (d4),
    .Q   (q4),
    .rst (rst)
  );

  // Clock period is 10 ns, with the first rising edge at t=10.
  initial begin
    clk = 1'b0;
    #10;
    forever begin
      clk = 1'b1;
      #5;
      clk = 1'b0;
      #5;
    end
  end

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at t=%0t: got %h, expected %h", tag, $time, observed, expected);
    end
  endtask

  task automatic pushExpect(input string tag, input bit wide, input logic [3:0] exp);
    sb_entry_t e;
    e.tag  = tag;
    e.wide = wide;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drainCheck();
    sb_entry_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput(e.tag, e.wide ? q4 : {3'b000, q1}, e.exp);
    end
  endtask

  task automatic applyStimulus(input logic v1, input logic [3:0] v4, input string tag);
    d1 = v1;
    d4 = v4;
    pushExpect({tag, "_n"}, 1'b0, {3'b000, v1});
    pushExpect({tag, "_w"}, 1'b1, v4);
  endtask

  initial begin
    logic       r1;
    logic [3:0] r4;

    rst = 1'b1;
    d1  = 1'b0;
    d4  = 4'h0;
    #1;
    pushExpect("reset_n", 1'b0, 4'h0);
    pushExpect("reset_w", 1'b1, 4'hA);
    drainCheck();

    // A clock edge during reset must be ignored even with D=1.
    #1;
    d1 = 1'b1;
    d4 = 4'h3;
    @(posedge clk); #1;
    pushExpect("rst_hold_n", 1'b0, 4'h0);
    pushExpect("rst_hold_w", 1'b1, 4'hA);
    drainCheck();

    #2 rst = 1'b0;
    #1;
    pushExpect("release_n", 1'b0, 4'h0);
    pushExpect("release_w", 1'b1, 4'hA);
    drainCheck();

    @(posedge clk); #1;
    pushExpect("capture1_n", 1'b0, 4'h1);
    pushExpect("capture1_w", 1'b1, 4'h3);
    drainCheck();

    // D toggles between edges, across a falling edge; Q must hold.
    d1 = 1'b0;
    #2 d1 = 1'b1;
    #4 d1 = 1'b0;
    #1;
    pushExpect("hold_n", 1'b0, 4'h1);
    drainCheck();

    @(posedge clk); #1;
    pushExpect("capture0_n", 1'b0, 4'h0);
    drainCheck();
    d1 = 1'b1;

    @(posedge clk); #1;
    pushExpect("capture1b_n", 1'b0, 4'h1);
    drainCheck();

    #2 rst = 1'b1;
    #1;
    pushExpect("async_n", 1'b0, 4'h0);
    pushExpect("async_w", 1'b1, 4'hA);
    drainCheck();

    @(posedge clk); #1;
    pushExpect("async_edge_n", 1'b0, 4'h0);
    pushExpect("async_edge_w", 1'b1, 4'hA);
    drainCheck();

    #2 rst = 1'b0;
    #1;
    pushExpect("release2_n", 1'b0, 4'h0);
    drainCheck();

    @(posedge clk); #1;
    pushExpect("first_edge_n", 1'b0, 4'h1);
    pushExpect("first_edge_w", 1'b1, 4'h3);
    drainCheck();

    // Reset asserted in the same timestep as a rising edge must win.
    @(posedge clk);
    rst = 1'b1;
    #1;
    pushExpect("rst_vs_edge_n", 1'b0, 4'h0);
    pushExpect("rst_vs_edge_w", 1'b1, 4'hA);
    drainCheck();
    #2 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      r1 = 1'($urandom_range(0, 1));
      r4 = (i == 0) ? 4'h5 : (i == 1) ? 4'hF : 4'($urandom_range(0, 15));
      applyStimulus(r1, r4, $sformatf("seq%0d", i));
      @(posedge clk); #1;
      drainCheck();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
